// File: rtl/fsk_mod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_mod_pkg
//  Description : Shared definitions for the FSK modulator: channel index
//                width, BLE channel-index to RF-channel map, synthesizer
//                frequency base constants and modulator state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package fsk_mod_pkg;

    // Width of the BLE channel index presented to the modulator.
    localparam int c_CH_IDX_W = 6;

    // Synthesizer offsets are expressed in kHz above 2400 MHz.
    // RF channel k sits at 2402 + 2k MHz, i.e. 2000 + 2000*k kHz.
    localparam int unsigned c_BASE_KHZ    = 32'd2000;
    localparam int unsigned c_RF_STEP_KHZ = 32'd2000;

    // Modulator sequencing states, explicitly encoded on 3 bits.
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PA_UP   = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_TAIL    = 3'd3,
        ST_PA_DOWN = 3'd4
    } fsk_state_t;

    // BLE channel index -> RF channel number. Data channels skip the
    // advertising slots (RF 0, 12, 39); indices 37..39 are the advertising
    // channels themselves. Out-of-range indices fall back to RF 0.
    function automatic int unsigned ch_to_rf(input int unsigned idx);
        int unsigned rf;
        if (idx <= 32'd10) begin
            rf = idx + 32'd1;
        end else if (idx <= 32'd36) begin
            rf = idx + 32'd2;
        end else if (idx == 32'd38) begin
            rf = 32'd12;
        end else if (idx == 32'd39) begin
            rf = 32'd39;
        end else begin
            rf = 32'd0;
        end
        return rf;
    endfunction

    // Channel centre frequency in kHz above 2400 MHz.
    function automatic int unsigned ch_center_khz(input int unsigned idx);
        return c_BASE_KHZ + c_RF_STEP_KHZ * ch_to_rf(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsk_mod_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_mod_fifo
//  Description : Synchronous single-bit FIFO, depth 2**AW. Decouples the
//                upstream bit strobes from the modulator bit timer.
//                A push into a full FIFO succeeds only when a pop happens in
//                the same cycle; otherwise it is ignored (the caller flags
//                the overflow). Flush empties the FIFO in one cycle.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                i_flush        empty the FIFO (same effect as rst)
//                i_push, i_din  write strobe and data bit
//                i_pop          read strobe (ignored when empty)
//                o_dout         bit at the head of the FIFO
//                o_full,o_empty occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module fsk_mod_fifo #(
    parameter int AW = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_push,
    input  logic i_din,
    input  logic i_pop,
    output logic o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int c_DEPTH = 1 << AW;

    logic [c_DEPTH-1:0] r_mem;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;

    logic               w_do_pop;
    logic               w_do_push;

    assign o_full    = (r_count == (AW+1)'(c_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rd_ptr];

    // A pop frees the slot the simultaneous push needs, so a full FIFO
    // still accepts a write when it is being read in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the occupancy count guards every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fsk_mod.sv
`default_nettype none
// ============================================================================
//  Module      : fsk_mod
//  Description : Transmit-side FSK modulator. Buffers transmitter bits in a
//                small FIFO and turns them into a paced stream of
//                synthesizer frequency words with a linear ramp at every
//                bit transition, framed by PA warm-up and cool-down phases.
//  Ports       : clk, rst     clock, synchronous active-high reset
//                en           block enable; low aborts, flushes and idles
//                ch_idx       BLE channel index, latched when leaving OFF
//                tx, tx_valid transmitter bit and one-cycle strobe
//                freq_word    kHz offset above 2400 MHz
//                freq_valid   freq_word is meaningful
//                pa_en        power-amplifier enable
//                busy         sequencer not in OFF
//                ovf          sticky: a bit was dropped on a full FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module fsk_mod
    import fsk_mod_pkg::*;
#(
    parameter int BIT_CYCLES = 16,
    parameter int RAMP_STEPS = 4,
    parameter int DEV_KHZ    = 250,
    parameter int PA_CYCLES  = 32,
    parameter int FIFO_AW    = 2,
    parameter int FREQ_W     = 17,
    parameter int CH_IDX_W   = c_CH_IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CH_IDX_W-1:0] ch_idx,
    input  logic                tx,
    input  logic                tx_valid,
    output logic [FREQ_W-1:0]   freq_word,
    output logic                freq_valid,
    output logic                pa_en,
    output logic                busy,
    output logic                ovf
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    if (RAMP_STEPS < 1 || (RAMP_STEPS & (RAMP_STEPS - 1)) != 0) begin : g_bad_ramp_pow2
        $error("fsk_mod: RAMP_STEPS must be a power of 2");
    end
    if (RAMP_STEPS > BIT_CYCLES) begin : g_bad_ramp_len
        $error("fsk_mod: RAMP_STEPS must not exceed BIT_CYCLES");
    end

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_CNT_MAX = (BIT_CYCLES > PA_CYCLES) ? BIT_CYCLES : PA_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_RAMP_SH = $clog2(RAMP_STEPS);
    // Counter value during which the final (snapping) ramp step is taken.
    // The first step is taken on the boundary edge itself, so in-period
    // steps run at counts 0 .. RAMP_STEPS-2.
    localparam int c_SNAP_AT = RAMP_STEPS - 2;

    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(BIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PA_LAST  = c_CNT_W'(PA_CYCLES - 1);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    fsk_state_t                 r_state;
    fsk_state_t                 w_state_nx;
    logic [c_CNT_W-1:0]         r_cnt;
    logic [c_CNT_W-1:0]         w_cnt_nx;
    logic [FREQ_W-1:0]          r_freq;
    logic [FREQ_W-1:0]          w_freq_nx;
    logic [FREQ_W-1:0]          r_tgt;
    logic [FREQ_W-1:0]          w_tgt_nx;
    logic [FREQ_W-1:0]          r_center;
    logic [FREQ_W-1:0]          w_center_nx;
    logic signed [FREQ_W:0]     r_step;
    logic signed [FREQ_W:0]     w_step_nx;
    logic                       r_ovf;

    logic [FREQ_W-1:0]          w_center_in;
    logic [FREQ_W-1:0]          w_bit_tgt;
    logic [FREQ_W-1:0]          w_start_tgt;
    logic signed [FREQ_W:0]     w_diff;
    logic signed [FREQ_W:0]     w_step_new;
    logic [FREQ_W-1:0]          w_start_next;
    logic [FREQ_W-1:0]          w_ramp_next;
    logic                       w_start;
    logic                       w_ramp_live;
    logic                       w_pop;

    logic                       w_fifo_dout;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;

    // ------------------------------------------------------------------
    // Bit FIFO
    // ------------------------------------------------------------------
    fsk_mod_fifo #(
        .AW      (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (!en),
        .i_push  (tx_valid && en),
        .i_din   (tx),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Ramp datapath
    // ------------------------------------------------------------------
    assign w_center_in = FREQ_W'(ch_center_khz(32'(ch_idx)));
    assign w_bit_tgt   = w_fifo_dout ? (r_center + FREQ_W'(DEV_KHZ))
                                     : (r_center - FREQ_W'(DEV_KHZ));

    // At a period boundary the next target is the popped bit, or the
    // centre when the FIFO has run dry (entering TAIL).
    assign w_start_tgt = w_fifo_empty ? r_center : w_bit_tgt;

    // Step is fixed for the whole ramp, derived from the value at the
    // start of the period; arithmetic shift keeps the sign for falling ramps.
    assign w_diff       = $signed({1'b0, w_start_tgt}) - $signed({1'b0, r_freq});
    assign w_step_new   = w_diff >>> c_RAMP_SH;
    assign w_start_next = FREQ_W'($signed({1'b0, r_freq}) + w_step_new);
    assign w_ramp_next  = FREQ_W'($signed({1'b0, r_freq}) + r_step);

    assign w_pop = w_start && !w_fifo_empty && en;

    // ------------------------------------------------------------------
    // Sequencer: next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt + c_CNT_W'(1);
        w_freq_nx   = r_freq;
        w_tgt_nx    = r_tgt;
        w_step_nx   = r_step;
        w_center_nx = r_center;
        w_start     = 1'b0;
        w_ramp_live = 1'b0;

        case (r_state)
            ST_OFF: begin
                w_cnt_nx = '0;
                if (tx_valid) begin
                    w_state_nx  = ST_PA_UP;
                    w_center_nx = w_center_in;
                    w_freq_nx   = w_center_in;
                end
            end

            ST_PA_UP: begin
                if (r_cnt == c_PA_LAST) begin
                    w_state_nx = ST_ACTIVE;
                    w_start    = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_start = 1'b1;
                    if (w_fifo_empty) begin
                        w_state_nx = ST_TAIL;
                    end
                end else begin
                    w_ramp_live = 1'b1;
                end
            end

            ST_TAIL: begin
                if (r_cnt == c_BIT_LAST) begin
                    if (!w_fifo_empty) begin
                        w_state_nx = ST_ACTIVE;
                        w_start    = 1'b1;
                    end else begin
                        w_state_nx = ST_PA_DOWN;
                        w_freq_nx  = r_center;
                        w_cnt_nx   = '0;
                    end
                end else begin
                    w_ramp_live = 1'b1;
                end
            end

            ST_PA_DOWN: begin
                if (r_cnt == c_PA_LAST) begin
                    if (!w_fifo_empty) begin
                        // Bits arrived while cooling down: warm up again.
                        w_state_nx = ST_PA_UP;
                        w_freq_nx  = r_center;
                        w_cnt_nx   = '0;
                    end else begin
                        w_state_nx = ST_OFF;
                        w_freq_nx  = '0;
                    end
                end
            end

            default: begin
                w_state_nx = ST_OFF;
                w_freq_nx  = '0;
            end
        endcase

        // In-period ramp: accumulate the fixed step, snapping exactly onto
        // the target on the last step so truncation never leaves a residue.
        if (w_ramp_live && (int'(r_cnt) <= c_SNAP_AT)) begin
            if (int'(r_cnt) == c_SNAP_AT) begin
                w_freq_nx = r_tgt;
            end else begin
                w_freq_nx = w_ramp_next;
            end
        end

        // New period: latch target and step, and take the first step now.
        if (w_start) begin
            w_tgt_nx  = w_start_tgt;
            w_step_nx = w_step_new;
            w_freq_nx = w_start_next;
            w_cnt_nx  = '0;
        end

        // Disable overrides everything.
        if (!en) begin
            w_state_nx  = ST_OFF;
            w_cnt_nx    = '0;
            w_freq_nx   = '0;
            w_tgt_nx    = '0;
            w_step_nx   = '0;
            w_center_nx = r_center;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_OFF;
            r_cnt    <= '0;
            r_freq   <= '0;
            r_tgt    <= '0;
            r_step   <= '0;
            r_center <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_freq   <= w_freq_nx;
            r_tgt    <= w_tgt_nx;
            r_step   <= w_step_nx;
            r_center <= w_center_nx;
        end
    end

    // Sticky overflow: a strobe met a full FIFO that was not being read.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_ovf <= 1'b0;
        end else if (tx_valid && w_fifo_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign freq_valid = (r_state != ST_OFF);
    assign busy       = (r_state != ST_OFF);
    assign pa_en      = (r_state == ST_PA_UP) || (r_state == ST_ACTIVE) ||
                        (r_state == ST_TAIL);
    assign freq_word  = freq_valid ? r_freq : '0;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire
